// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Hazard unit for a 5-stage pipeline: detects load-use hazards, holds the
// pipeline during data-memory wait requests and flushes the front end on a
// taken branch/jump resolved in MEM. A branch seen while memory is busy is
// remembered and applied as a single flush once the wait ends.
// All control outputs are combinational from the current state and inputs.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_IFID_Rs, in_IFID_Rt        source registers of the instruction in ID
//   in_IDEX_MemRead, in_IDEX_Rt   load in EX and its destination register
//   in_MEM_PCSrc                  taken branch/jump resolved in MEM
//   in_MemBusy                    data-memory wait request
//   out_PCWrite, out_IFID_Write   PC and IF/ID load enables
//   out_IFID_Flush, out_IDEX_Flush, out_EXMEM_Flush  pipeline register clears
//   out_PipeHold                  freezes ID/EX, EX/MEM, MEM/WB
//   out_Stalled                   high in load-use stall and busy cycles
//   out_StallCount                cumulative saturating stall-cycle count
//
// Optional feature: define HAZARD_STALL_COUNTER_EN to build the stall
// counter; otherwise out_StallCount is tied to zero and no register exists.
module pipeline_hazard_controller #(
  parameter int unsigned STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4:0]                   in_IFID_Rs,
  input  logic [4:0]                   in_IFID_Rt,
  input  logic                         in_IDEX_MemRead,
  input  logic [4:0]                   in_IDEX_Rt,
  input  logic                         in_MEM_PCSrc,
  input  logic                         in_MemBusy,
  output logic                         out_PCWrite,
  output logic                         out_IFID_Write,
  output logic                         out_IFID_Flush,
  output logic                         out_IDEX_Flush,
  output logic                         out_EXMEM_Flush,
  output logic                         out_PipeHold,
  output logic                         out_Stalled,
  output logic [STALL_COUNT_WIDTH-1:0] out_StallCount
);

  typedef enum logic [1:0] {RUN, LOADUSE, MEMWAIT, FLUSH} state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_flush_pend;
  logic   w_flush_pend_next;
  logic   w_load_use;

  // Load whose destination (never r0) feeds the instruction in decode
  assign w_load_use = in_IDEX_MemRead && (in_IDEX_Rt != 5'd0) &&
                      ((in_IDEX_Rt == in_IFID_Rs) || (in_IDEX_Rt == in_IFID_Rt));

  // Next state and outputs; priority reset > busy > flush > load-use
  always_comb begin
    out_PCWrite       = 1'b1;
    out_IFID_Write    = 1'b1;
    out_IFID_Flush    = 1'b0;
    out_IDEX_Flush    = 1'b0;
    out_EXMEM_Flush   = 1'b0;
    out_PipeHold      = 1'b0;
    out_Stalled       = 1'b0;
    w_next_state      = RUN;
    w_flush_pend_next = r_flush_pend;

    if (reset) begin
      out_PCWrite       = 1'b0;
      out_IFID_Write    = 1'b0;
      out_IFID_Flush    = 1'b1;
      out_IDEX_Flush    = 1'b1;
      out_EXMEM_Flush   = 1'b1;
      w_flush_pend_next = 1'b0;
    end else if (in_MemBusy) begin
      out_PCWrite    = 1'b0;
      out_IFID_Write = 1'b0;
      out_PipeHold   = 1'b1;
      out_Stalled    = 1'b1;
      w_next_state   = MEMWAIT;
      // A redirect during the wait is only remembered, never counted
      if (in_MEM_PCSrc) w_flush_pend_next = 1'b1;
    end else if (in_MEM_PCSrc || r_flush_pend) begin
      // Flush wins over a simultaneous load-use: the stalled instruction dies anyway
      out_IFID_Flush    = 1'b1;
      out_IDEX_Flush    = 1'b1;
      out_EXMEM_Flush   = 1'b1;
      w_next_state      = FLUSH;
      w_flush_pend_next = 1'b0;
    end else if (w_load_use && (r_state != LOADUSE)) begin
      out_PCWrite    = 1'b0;
      out_IFID_Write = 1'b0;
      out_IDEX_Flush = 1'b1;
      out_Stalled    = 1'b1;
      w_next_state   = LOADUSE;
    end
  end

  // State and pending-flush registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_flush_pend <= w_flush_pend_next;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (out_Stalled && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STALL_COUNT_WIDTH'(1);
    end
  end

  assign out_StallCount = r_stall_count;
`else
  assign out_StallCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed bench for pipeline_hazard_controller. Each step drives inputs on
// the falling edge and checks the combinational outputs 1 ns later against
// hand-written vectors; the expected stall count is tracked from those
// vectors. With HAZARD_STALL_COUNTER_EN a narrow second instance checks
// counter saturation.
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 16;

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PipeHold, Stalled}
  localparam logic [6:0] RUN_O  = 7'b1100000;
  localparam logic [6:0] RST_O  = 7'b0011100;
  localparam logic [6:0] LU_O   = 7'b0001001;
  localparam logic [6:0] BUSY_O = 7'b0000011;
  localparam logic [6:0] FL_O   = 7'b1111100;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    in_IFID_Rs, in_IFID_Rt, in_IDEX_Rt;
  logic          in_IDEX_MemRead, in_MEM_PCSrc, in_MemBusy;
  logic          out_PCWrite, out_IFID_Write, out_IFID_Flush, out_IDEX_Flush;
  logic          out_EXMEM_Flush, out_PipeHold, out_Stalled;
  logic [CW-1:0] out_StallCount;
  logic [6:0]    w_out;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.STALL_COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_IFID_Rs(in_IFID_Rs), .in_IFID_Rt(in_IFID_Rt),
    .in_IDEX_MemRead(in_IDEX_MemRead), .in_IDEX_Rt(in_IDEX_Rt),
    .in_MEM_PCSrc(in_MEM_PCSrc), .in_MemBusy(in_MemBusy),
    .out_PCWrite(out_PCWrite), .out_IFID_Write(out_IFID_Write),
    .out_IFID_Flush(out_IFID_Flush), .out_IDEX_Flush(out_IDEX_Flush),
    .out_EXMEM_Flush(out_EXMEM_Flush), .out_PipeHold(out_PipeHold),
    .out_Stalled(out_Stalled), .out_StallCount(out_StallCount)
  );

  assign w_out = {out_PCWrite, out_IFID_Write, out_IFID_Flush, out_IDEX_Flush,
                  out_EXMEM_Flush, out_PipeHold, out_Stalled};

`ifdef HAZARD_STALL_COUNTER_EN
  logic       s_PCWrite, s_IFID_Write, s_IFID_Flush, s_IDEX_Flush;
  logic       s_EXMEM_Flush, s_PipeHold, s_Stalled;
  logic [2:0] s_StallCount;

  pipeline_hazard_controller #(.STALL_COUNT_WIDTH(3)) dut_sat (
    .clk(clk), .reset(reset),
    .in_IFID_Rs(in_IFID_Rs), .in_IFID_Rt(in_IFID_Rt),
    .in_IDEX_MemRead(in_IDEX_MemRead), .in_IDEX_Rt(in_IDEX_Rt),
    .in_MEM_PCSrc(in_MEM_PCSrc), .in_MemBusy(in_MemBusy),
    .out_PCWrite(s_PCWrite), .out_IFID_Write(s_IFID_Write),
    .out_IFID_Flush(s_IFID_Flush), .out_IDEX_Flush(s_IDEX_Flush),
    .out_EXMEM_Flush(s_EXMEM_Flush), .out_PipeHold(s_PipeHold),
    .out_Stalled(s_Stalled), .out_StallCount(s_StallCount)
  );
`endif

  function automatic logic [CW-1:0] exp_count();
`ifdef HAZARD_STALL_COUNTER_EN
    return exp_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic drv(input logic rst, input logic busy, input logic pcsrc,
                     input logic mr, input logic [4:0] idex_rt,
                     input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    reset           = rst;
    in_MemBusy      = busy;
    in_MEM_PCSrc    = pcsrc;
    in_IDEX_MemRead = mr;
    in_IDEX_Rt      = idex_rt;
    in_IFID_Rs      = rs;
    in_IFID_Rt      = rt;
  endtask

  // Check outputs and count, then advance the expected count for this cycle
  task automatic step(input string tag, input logic [6:0] exp);
    logic [CW-1:0] ec;
    #1;
    ec = exp_count();
    n_assert++;
    assert (w_out === exp) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, w_out, exp);
    end
    n_assert++;
    assert (out_StallCount === ec) else begin
      n_fail++;
      $error("FAIL %s count: observed %0d expected %0d", tag, out_StallCount, ec);
    end
    if (reset) exp_cnt = '0;
    else if (exp[0] && (exp_cnt != '1)) exp_cnt = exp_cnt + CW'(1);
  endtask

  initial begin
    reset = 1'b1; in_MemBusy = 1'b0; in_MEM_PCSrc = 1'b0; in_IDEX_MemRead = 1'b0;
    in_IDEX_Rt = 5'd0; in_IFID_Rs = 5'd0; in_IFID_Rt = 5'd0;
    @(posedge clk);

    // Reset values
    drv(1, 0, 0, 0, 0, 0, 0);    step("reset",          RST_O);
    drv(1, 0, 1, 1, 8, 8, 0);    step("reset_inputs",   RST_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("run_idle",       RUN_O);

    // Load-use on Rs, one stall cycle then LOADUSE with hazard suppressed
    drv(0, 0, 0, 1, 8, 8, 3);    step("lu_rs_stall",    LU_O);
    drv(0, 0, 0, 1, 8, 8, 3);    step("lu_rs_loaduse",  RUN_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("lu_rs_after",    RUN_O);

    // Load-use on Rt
    drv(0, 0, 0, 1, 5, 3, 5);    step("lu_rt_stall",    LU_O);
    drv(0, 0, 0, 0, 0, 3, 5);    step("lu_rt_loaduse",  RUN_O);

    // Non-hazards: r0, no match, not a load
    drv(0, 0, 0, 1, 0, 4, 0);    step("zero_reg",       RUN_O);
    drv(0, 0, 0, 1, 9, 8, 7);    step("no_match",       RUN_O);
    drv(0, 0, 0, 0, 8, 8, 8);    step("not_load",       RUN_O);

    // Memory wait for 4 cycles
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);  step("busy4",          BUSY_O);
    end
    drv(0, 0, 0, 0, 0, 0, 0);    step("busy4_end",      RUN_O);

    // Branch during busy cycles 2 and 3 gives one flush after busy falls
    drv(0, 1, 0, 0, 0, 0, 0);    step("fb_busy1",       BUSY_O);
    drv(0, 1, 1, 0, 0, 0, 0);    step("fb_busy2",       BUSY_O);
    drv(0, 1, 1, 0, 0, 0, 0);    step("fb_busy3",       BUSY_O);
    drv(0, 1, 0, 0, 0, 0, 0);    step("fb_busy4",       BUSY_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("fb_flush",       FL_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("fb_single",      RUN_O);

    // Plain branch flush
    drv(0, 0, 1, 0, 0, 0, 0);    step("br_flush",       FL_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("br_after",       RUN_O);

    // Branch and load-use together: flush only
    drv(0, 0, 1, 1, 6, 6, 0);    step("collision",      FL_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("coll_after",     RUN_O);

    // Busy outranks load-use
    drv(0, 1, 0, 1, 6, 6, 0);    step("busy_lu",        BUSY_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("busy_lu_end",    RUN_O);

    // Reset in MEMWAIT with a pending flush discards it
    drv(0, 1, 1, 0, 0, 0, 0);    step("rst_pend",       BUSY_O);
    drv(1, 1, 0, 0, 0, 0, 0);    step("rst_in_wait",    RST_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("rst_release",    RUN_O);
    drv(0, 0, 0, 0, 0, 0, 0);    step("rst_no_flush",   RUN_O);

    // Long wait: 9 stalls drive the narrow counter to saturation
    for (int i = 0; i < 9; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);  step("busy9",          BUSY_O);
    end
    drv(0, 0, 0, 0, 0, 0, 0);    step("busy9_end",      RUN_O);

`ifdef HAZARD_STALL_COUNTER_EN
    n_assert++;
    assert (s_StallCount === 3'd7) else begin
      n_fail++;
      $error("FAIL sat_count: observed %0d expected 7", s_StallCount);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
